// File: rtl/peak_bin_tracker_pkg.sv
// Shared defaults and helpers for the per-frame top-N peak tracker.
package peak_bin_tracker_pkg;

    localparam int unsigned DefMagWidth = 96;
    localparam int unsigned DefKWidth   = 12;
    localparam int unsigned DefFrameLen = 4096;
    localparam int unsigned DefNumPeaks = 4;
    localparam int unsigned DefKMin     = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/peak_bin_tracker_if.sv
// Bin input stream and frame-result handshake of the peak tracker.
interface peak_bin_tracker_if #(
    parameter int unsigned MAG_WIDTH = peak_bin_tracker_pkg::DefMagWidth,
    parameter int unsigned K_WIDTH   = peak_bin_tracker_pkg::DefKWidth,
    parameter int unsigned NUM_PEAKS = peak_bin_tracker_pkg::DefNumPeaks,
    parameter int unsigned CNT_WIDTH = peak_bin_tracker_pkg::clog2(NUM_PEAKS + 1)
);

    logic                           in_valid;
    logic [MAG_WIDTH-1:0]           in_mag;
    logic [K_WIDTH-1:0]             in_k;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_PEAKS*K_WIDTH-1:0]   out_k;
    logic [NUM_PEAKS*MAG_WIDTH-1:0] out_mag;
    logic [CNT_WIDTH-1:0]           out_count;

    modport master (
        output in_valid, in_mag, in_k, out_ready,
        input  out_valid, out_k, out_mag, out_count
    );

    modport slave (
        input  in_valid, in_mag, in_k, out_ready,
        output out_valid, out_k, out_mag, out_count
    );

endinterface

// File: rtl/peak_bin_tracker_slot.sv
// One cell of the sorted peak list: takes a new entry or shifts in its upper neighbour.
module peak_bin_tracker_slot #(
    parameter int unsigned MAG_WIDTH = 96,
    parameter int unsigned K_WIDTH   = 12
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_clear,
    input  logic                 i_ins,
    input  logic [MAG_WIDTH-1:0] i_mag,
    input  logic [K_WIDTH-1:0]   i_k,
    input  logic                 i_take_above,
    input  logic                 i_above_valid,
    input  logic [MAG_WIDTH-1:0] i_above_mag,
    input  logic [K_WIDTH-1:0]   i_above_k,
    output logic                 o_take,
    output logic                 o_valid,
    output logic [MAG_WIDTH-1:0] o_mag,
    output logic [K_WIDTH-1:0]   o_k,
    output logic                 o_valid_d,
    output logic [MAG_WIDTH-1:0] o_mag_d,
    output logic [K_WIDTH-1:0]   o_k_d
);

    logic                 r_valid;
    logic [MAG_WIDTH-1:0] r_mag;
    logic [K_WIDTH-1:0]   r_k;
    logic                 w_take_here;

    // Strict compare keeps the earlier bin ahead on ties.
    assign w_take_here = i_ins && !i_take_above && (!r_valid || (i_mag > r_mag));
    assign o_take      = i_take_above || w_take_here;

    always_comb begin
        o_valid_d = r_valid;
        o_mag_d   = r_mag;
        o_k_d     = r_k;
        if (w_take_here) begin
            o_valid_d = 1'b1;
            o_mag_d   = i_mag;
            o_k_d     = i_k;
        end else if (i_take_above) begin
            o_valid_d = i_above_valid;
            o_mag_d   = i_above_mag;
            o_k_d     = i_above_k;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || i_clear) begin
            r_valid <= 1'b0;
            r_mag   <= '0;
            r_k     <= '0;
        end else begin
            r_valid <= o_valid_d;
            r_mag   <= o_mag_d;
            r_k     <= o_k_d;
        end
    end

    assign o_valid = r_valid;
    assign o_mag   = r_mag;
    assign o_k     = r_k;

endmodule

// File: rtl/peak_bin_tracker.sv
// Per-frame top-N magnitude tracker with a one-deep valid/ready result register.
module peak_bin_tracker
    import peak_bin_tracker_pkg::*;
#(
    parameter int unsigned MAG_WIDTH = DefMagWidth,
    parameter int unsigned K_WIDTH   = DefKWidth,
    parameter int unsigned FRAME_LEN = DefFrameLen,
    parameter int unsigned NUM_PEAKS = DefNumPeaks,
    parameter int unsigned K_MIN     = DefKMin
) (
    input  logic               clock,
    input  logic               reset_n,
    peak_bin_tracker_if.slave  bus,
    output logic               o_frame_overrun
);

    localparam int unsigned CntWidth = clog2(NUM_PEAKS + 1);

    logic                 w_end;
    logic                 w_ins;
    logic                 w_load;
    logic                 w_chain   [NUM_PEAKS+1];
    logic                 w_valid_q [NUM_PEAKS];
    logic [MAG_WIDTH-1:0] w_mag_q   [NUM_PEAKS];
    logic [K_WIDTH-1:0]   w_k_q     [NUM_PEAKS];
    logic                 w_valid_d [NUM_PEAKS];
    logic [MAG_WIDTH-1:0] w_mag_d   [NUM_PEAKS];
    logic [K_WIDTH-1:0]   w_k_d     [NUM_PEAKS];

    logic [NUM_PEAKS*K_WIDTH-1:0]   w_res_k;
    logic [NUM_PEAKS*MAG_WIDTH-1:0] w_res_mag;
    logic [CntWidth-1:0]            w_res_cnt;

    logic                           r_out_valid;
    logic [NUM_PEAKS*K_WIDTH-1:0]   r_out_k;
    logic [NUM_PEAKS*MAG_WIDTH-1:0] r_out_mag;
    logic [CntWidth-1:0]            r_out_cnt;
    logic                           r_overrun;

    assign w_end = bus.in_valid && (bus.in_k == K_WIDTH'(FRAME_LEN - 1));
    assign w_ins = bus.in_valid && (bus.in_k >= K_WIDTH'(K_MIN));

    assign w_chain[0] = 1'b0;

    for (genvar i = 0; i < NUM_PEAKS; i++) begin : g_slot
        logic                 w_above_valid;
        logic [MAG_WIDTH-1:0] w_above_mag;
        logic [K_WIDTH-1:0]   w_above_k;

        if (i == 0) begin : g_first
            assign w_above_valid = 1'b0;
            assign w_above_mag   = '0;
            assign w_above_k     = '0;
        end else begin : g_rest
            assign w_above_valid = w_valid_q[i-1];
            assign w_above_mag   = w_mag_q[i-1];
            assign w_above_k     = w_k_q[i-1];
        end

        // The end beat's insertion still lands in the result; the register then clears.
        peak_bin_tracker_slot #(
            .MAG_WIDTH (MAG_WIDTH),
            .K_WIDTH   (K_WIDTH)
        ) u_slot (
            .clock         (clock),
            .reset_n       (reset_n),
            .i_clear       (w_end),
            .i_ins         (w_ins),
            .i_mag         (bus.in_mag),
            .i_k           (bus.in_k),
            .i_take_above  (w_chain[i]),
            .i_above_valid (w_above_valid),
            .i_above_mag   (w_above_mag),
            .i_above_k     (w_above_k),
            .o_take        (w_chain[i+1]),
            .o_valid       (w_valid_q[i]),
            .o_mag         (w_mag_q[i]),
            .o_k           (w_k_q[i]),
            .o_valid_d     (w_valid_d[i]),
            .o_mag_d       (w_mag_d[i]),
            .o_k_d         (w_k_d[i])
        );
    end

    always_comb begin
        w_res_k   = '0;
        w_res_mag = '0;
        w_res_cnt = '0;
        for (int i = 0; i < NUM_PEAKS; i++) begin
            if (w_valid_d[i]) begin
                w_res_k[i*K_WIDTH +: K_WIDTH]       = w_k_d[i];
                w_res_mag[i*MAG_WIDTH +: MAG_WIDTH] = w_mag_d[i];
                w_res_cnt                           = w_res_cnt + CntWidth'(1);
            end
        end
    end

    assign w_load = w_end && (!r_out_valid || bus.out_ready);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_k     <= '0;
            r_out_mag   <= '0;
            r_out_cnt   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_end && r_out_valid && !bus.out_ready;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_k     <= w_res_k;
                r_out_mag   <= w_res_mag;
                r_out_cnt   <= w_res_cnt;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_k       = r_out_k;
    assign bus.out_mag     = r_out_mag;
    assign bus.out_count   = r_out_cnt;
    assign o_frame_overrun = r_overrun;

endmodule

// File: tb/tb_peak_bin_tracker.sv
// Directed bench for peak_bin_tracker: FRAME_LEN 8, three peaks, K_MIN 1.
module tb_peak_bin_tracker;

    localparam int unsigned MW = 16;
    localparam int unsigned KW = 3;
    localparam int unsigned NP = 3;

    logic clock;
    logic reset_n;
    logic frame_overrun;
    int   n_run;
    int   n_fail;

    peak_bin_tracker_if #(.MAG_WIDTH(MW), .K_WIDTH(KW), .NUM_PEAKS(NP)) bus ();

    peak_bin_tracker #(
        .MAG_WIDTH (MW),
        .K_WIDTH   (KW),
        .FRAME_LEN (8),
        .NUM_PEAKS (NP),
        .K_MIN     (1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .bus             (bus),
        .o_frame_overrun (frame_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input logic rdy);
        @(negedge clock);
        bus.in_valid  = 1'b0;
        bus.in_k      = '0;
        bus.in_mag    = '0;
        bus.out_ready = rdy;
    endtask

    task automatic beat(input logic v, input int k, input int mag, input logic rdy);
        @(negedge clock);
        bus.in_valid  = v;
        bus.in_k      = KW'(k);
        bus.in_mag    = MW'(mag);
        bus.out_ready = rdy;
    endtask

    task automatic frame(input int m[8], input logic [7:0] vm, input logic rdy_body,
                         input logic rdy_end);
        for (int k = 0; k < 8; k++) begin
            beat(vm[k], k, m[k], (k == 7) ? rdy_end : rdy_body);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [8:0] k,
                           input logic [47:0] mag, input logic [1:0] cnt);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
        chk({tag, ".k"},     64'(bus.out_k),     64'(k));
        chk({tag, ".mag"},   64'(bus.out_mag),   64'(mag));
        chk({tag, ".count"}, 64'(bus.out_count), 64'(cnt));
    endtask

    initial begin
        int m1[8];
        int m2[8];
        int mb[8];
        int mz[8];
        m1 = '{100, 5, 9, 2, 9, 7, 1, 3};
        m2 = '{0, 0, 4, 0, 0, 0, 0, 6};
        mb = '{0, 1, 2, 3, 4, 5, 6, 7};
        mz = '{0, 0, 0, 0, 0, 0, 0, 0};
        n_run  = 0;
        n_fail = 0;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_k      = '0;
        bus.in_mag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk_out("reset", 1'b0, 9'h0, 48'h0, 2'd0);
        chk("reset.overrun", 64'(frame_overrun), 64'd0);
        reset_n = 1'b1;

        // Basic ranking, tie order, k0 rejection
        frame(m1, 8'hff, 1'b1, 1'b1);
        idle(1'b1);
        chk_out("t1", 1'b1, {3'd5, 3'd4, 3'd2}, {16'd7, 16'd9, 16'd9}, 2'd3);
        chk("t1.overrun", 64'(frame_overrun), 64'd0);
        idle(1'b1);
        chk_out("t1.consumed", 1'b0, {3'd5, 3'd4, 3'd2}, {16'd7, 16'd9, 16'd9}, 2'd3);

        // Partially filled list
        frame(m2, 8'b1000_0100, 1'b1, 1'b1);
        idle(1'b1);
        chk_out("t2", 1'b1, {3'd0, 3'd2, 3'd7}, {16'd0, 16'd4, 16'd6}, 2'd2);
        idle(1'b1);
        chk("t2.consumed", 64'(bus.out_valid), 64'd0);

        // Backpressure: second result dropped with overrun pulse
        frame(m1, 8'hff, 1'b0, 1'b0);
        idle(1'b0);
        chk_out("t3.first", 1'b1, {3'd5, 3'd4, 3'd2}, {16'd7, 16'd9, 16'd9}, 2'd3);
        frame(mb, 8'hff, 1'b0, 1'b0);
        idle(1'b0);
        chk("t3.overrun", 64'(frame_overrun), 64'd1);
        chk_out("t3.held", 1'b1, {3'd5, 3'd4, 3'd2}, {16'd7, 16'd9, 16'd9}, 2'd3);
        idle(1'b0);
        chk("t3.overrun_end", 64'(frame_overrun), 64'd0);

        // Accept old and load new in the same cycle
        frame(mb, 8'hff, 1'b0, 1'b1);
        idle(1'b0);
        chk_out("t4", 1'b1, {3'd5, 3'd6, 3'd7}, {16'd5, 16'd6, 16'd7}, 2'd3);
        chk("t4.overrun", 64'(frame_overrun), 64'd0);
        idle(1'b0);
        chk("t4.hold", 64'(bus.out_valid), 64'd1);

        // Reset mid-frame discards partial list and pending result
        for (int k = 0; k < 4; k++) begin
            beat(1'b1, k, 100 - 10 * k, 1'b0);
        end
        @(negedge clock);
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk_out("t5.reset", 1'b0, 9'h0, 48'h0, 2'd0);
        chk("t5.overrun", 64'(frame_overrun), 64'd0);
        reset_n = 1'b1;
        frame(m2, 8'b1000_0100, 1'b1, 1'b1);
        idle(1'b1);
        chk_out("t5.after", 1'b1, {3'd0, 3'd2, 3'd7}, {16'd0, 16'd4, 16'd6}, 2'd2);

        // Zero magnitudes fill empty slots; beat right after end starts a new frame
        frame(mz, 8'hff, 1'b1, 1'b1);
        beat(1'b1, 1, 5, 1'b1);
        chk_out("t6.zero", 1'b1, {3'd3, 3'd2, 3'd1}, 48'h0, 2'd3);
        for (int k = 2; k < 7; k++) begin
            beat(1'b0, k, 9, 1'b1);
        end
        beat(1'b1, 7, 0, 1'b1);
        idle(1'b1);
        chk_out("t6.next", 1'b1, {3'd0, 3'd7, 3'd1}, {16'd0, 16'd0, 16'd5}, 2'd2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
